// File: rtl/synth_method_call_driver.sv
// ---------------------------------------------------------------------------
// synth_method_call_driver
//
// Upstream stimulus stage for a generated method block's req/busy/return
// port triple. After a power-up delay it issues N_CALLS invocations, watches
// each busy window, compares every return against EXPECT, and reports
// completed/failed call counts, a sticky timeout flag and a final pass/done.
//
// Optional feature macro:
//   SYNTH_METHOD_DRIVER_RETRY_EN - one retry of a call on its first ack
//                                  timeout (run timeouts never retry).
//
// Ports:
//   clk            in   1      single clock, posedge
//   reset          in   1      asynchronous, active-low reset
//   start          in   1      level; a run begins when high in S_IDLE
//   method_req     out  1      request to DUT
//   method_busy    in   1      DUT busy
//   method_return  in   RET_W  DUT return value
//   last_return    out  RET_W  return captured on most recent completion
//   call_count     out  16     completed invocations (timeouts included)
//   fail_count     out  16     mismatches plus timeouts
//   timeout        out  1      sticky: any ack or run timeout occurred
//   done           out  1      high once the run has finished
//   pass           out  1      done & no failures & no timeout
// ---------------------------------------------------------------------------
module synth_method_call_driver #(
  parameter int unsigned       RET_W       = 32,
  parameter logic [RET_W-1:0]  EXPECT      = RET_W'(1),
  parameter int unsigned       N_CALLS     = 4,
  parameter int unsigned       START_DELAY = 100,
  parameter int unsigned       ACK_TIMEOUT = 16,
  parameter int unsigned       RUN_TIMEOUT = 100000,
  parameter int unsigned       GAP         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             method_req,
  input  logic             method_busy,
  input  logic [RET_W-1:0] method_return,
  output logic [RET_W-1:0] last_return,
  output logic [15:0]      call_count,
  output logic [15:0]      fail_count,
  output logic             timeout,
  output logic             done,
  output logic             pass
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  // Terminal counts: a window of T cycles ends on the cycle whose count is T-1.
  localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(START_DELAY);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP);
  localparam logic [CNT_W-1:0] CALLS_LAST = CNT_W'(N_CALLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_RUN,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] delay_cnt;
  logic [ACK_W-1:0] ack_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
  logic             retried;
`endif

  // Saturating event counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Single-process run controller; all outputs except pass are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      method_req  <= 1'b0;
      last_return <= '0;
      call_count  <= '0;
      fail_count  <= '0;
      timeout     <= 1'b0;
      done        <= 1'b0;
      delay_cnt   <= '0;
      ack_cnt     <= '0;
      run_cnt     <= '0;
      gap_cnt     <= '0;
`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WAIT;
            delay_cnt <= DLY_LOAD;
          end
        end

        // Power-up delay; a zero delay still spends one cycle here.
        S_WAIT: begin
          if (delay_cnt == '0) begin
            state      <= S_REQ;
            method_req <= 1'b1;
            ack_cnt    <= '0;
          end else begin
            delay_cnt <= delay_cnt - DLY_W'(1);
          end
        end

        // Busy already high on entry counts as the ack.
        S_REQ: begin
          if (method_busy) begin
            state      <= S_RUN;
            method_req <= 1'b0;
            run_cnt    <= '0;
          end else if (ack_cnt == ACK_LAST) begin
            state      <= S_GAP;
            method_req <= 1'b0;
            timeout    <= 1'b1;
            gap_cnt    <= GAP_LOAD;
`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
            // First ack timeout of a call is retried without being counted.
            if (!retried) begin
              retried <= 1'b1;
            end else begin
              retried    <= 1'b0;
              call_count <= sat_inc(call_count);
              fail_count <= sat_inc(fail_count);
            end
`else
            call_count <= sat_inc(call_count);
            fail_count <= sat_inc(fail_count);
`endif
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end

        // Return is captured on the same edge that sees busy fall.
        S_RUN: begin
          if (!method_busy) begin
            state       <= S_CHECK;
            last_return <= method_return;
          end else if (run_cnt == RUN_LAST) begin
            state      <= S_GAP;
            timeout    <= 1'b1;
            gap_cnt    <= GAP_LOAD;
            call_count <= sat_inc(call_count);
            fail_count <= sat_inc(fail_count);
`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
            retried    <= 1'b0;
`endif
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end

        S_CHECK: begin
          state      <= S_GAP;
          gap_cnt    <= GAP_LOAD;
          call_count <= sat_inc(call_count);
          if (last_return != EXPECT) begin
            fail_count <= sat_inc(fail_count);
          end
`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
          retried    <= 1'b0;
`endif
        end

        // Idle spacing between calls; GAP=0 passes straight through in one cycle.
        S_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            if (call_count == CALLS_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_REQ;
              method_req <= 1'b1;
              ack_cnt    <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        // Terminal; only reset leaves.
        S_DONE: begin
          done <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          method_req <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  // Verdict derived from registered state.
  assign pass = done & (fail_count == '0) & ~timeout;

endmodule

// File: tb/tb_synth_method_call_driver.sv
// ---------------------------------------------------------------------------
// tb_synth_method_call_driver
//
// Two driver instances: "a" (START_DELAY=10, GAP=4, RUN_TIMEOUT=50, N_CALLS=4,
// 32-bit return, EXPECT=1) faces a configurable method model; "b" (START_DELAY=0,
// GAP=0, N_CALLS=3, 8-bit return, EXPECT=A5) faces a zero-latency model.
// Monitors record req pulse counts, widths and rise-to-rise spacing.
// ---------------------------------------------------------------------------
module tb_synth_method_call_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a
  logic        start_a, req_a, busy_a, to_a, done_a, pass_a;
  logic [31:0] ret_a, last_a;
  logic [15:0] calls_a, fails_a;
  // Instance b
  logic        start_b, req_b, busy_b, to_b, done_b, pass_b;
  logic [7:0]  ret_b, last_b;
  logic [15:0] calls_b, fails_b;

  synth_method_call_driver #(
    .RET_W(32), .EXPECT(32'd1), .N_CALLS(4), .START_DELAY(10),
    .ACK_TIMEOUT(16), .RUN_TIMEOUT(50), .GAP(4)
  ) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .method_req(req_a),
    .method_busy(busy_a), .method_return(ret_a), .last_return(last_a),
    .call_count(calls_a), .fail_count(fails_a), .timeout(to_a),
    .done(done_a), .pass(pass_a)
  );

  synth_method_call_driver #(
    .RET_W(8), .EXPECT(8'hA5), .N_CALLS(3), .START_DELAY(0),
    .ACK_TIMEOUT(16), .RUN_TIMEOUT(50), .GAP(0)
  ) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .method_req(req_b),
    .method_busy(busy_b), .method_return(ret_b), .last_return(last_b),
    .call_count(calls_b), .fail_count(fails_b), .timeout(to_b),
    .done(done_b), .pass(pass_b)
  );

  // Model a: 0 normal, 1 returns 0 on 3rd call, 2 never busy, 3 busy stuck after first ack.
  int mode_a = 0;
  int hold_a, ncalls_a;
  bit pend_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_a = 1'b0; hold_a = 0; pend_a = 1'b0; ncalls_a = 0; ret_a = 32'd0;
    end else if (mode_a != 2 && !(mode_a == 3 && busy_a)) begin
      if (hold_a > 0) begin
        hold_a = hold_a - 1;
        if (hold_a == 0) busy_a = 1'b0;
      end else if (pend_a) begin
        pend_a = 1'b0; busy_a = 1'b1; hold_a = 5; ncalls_a = ncalls_a + 1;
        ret_a = (mode_a == 1 && ncalls_a == 3) ? 32'd0 : 32'd1;
      end else if (req_a && !busy_a) begin
        pend_a = 1'b1;
      end
    end
  end

  // Model b: busy raised the same cycle req is seen, for one cycle.
  int hold_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_b = 1'b0; hold_b = 0; ret_b = 8'h00;
    end else if (hold_b > 0) begin
      hold_b = hold_b - 1;
      if (hold_b == 0) busy_b = 1'b0;
    end else if (req_b && !busy_b) begin
      busy_b = 1'b1; hold_b = 1; ret_b = 8'hA5;
    end
  end

  // req monitors: rises, min/max high width, spacing of the latest two rises.
  int cyc_a, rises_a, cur_a, maxw_a, minw_a, lastrise_a, ival_a;
  bit prev_a;
  always @(negedge clk) begin
    cyc_a = cyc_a + 1;
    if (!rst_n) begin
      rises_a = 0; cur_a = 0; maxw_a = 0; minw_a = 1000; prev_a = 1'b0; ival_a = 0; lastrise_a = 0;
    end else begin
      if (req_a) begin
        if (!prev_a) begin
          rises_a = rises_a + 1; cur_a = 0; ival_a = cyc_a - lastrise_a; lastrise_a = cyc_a;
        end
        cur_a = cur_a + 1;
        if (cur_a > maxw_a) maxw_a = cur_a;
      end else if (prev_a && cur_a < minw_a) begin
        minw_a = cur_a;
      end
      prev_a = req_a;
    end
  end

  int cyc_b, rises_b, cur_b, maxw_b, lastrise_b, ival_b;
  bit prev_b;
  always @(negedge clk) begin
    cyc_b = cyc_b + 1;
    if (!rst_n) begin
      rises_b = 0; cur_b = 0; maxw_b = 0; prev_b = 1'b0; ival_b = 0; lastrise_b = 0;
    end else begin
      if (req_b) begin
        if (!prev_b) begin
          rises_b = rises_b + 1; cur_b = 0; ival_b = cyc_b - lastrise_b; lastrise_b = cyc_b;
        end
        cur_b = cur_b + 1;
        if (cur_b > maxw_b) maxw_b = cur_b;
      end
      prev_b = req_b;
    end
  end

`ifdef SYNTH_METHOD_DRIVER_RETRY_EN
  localparam int T3_WINDOWS = 8;
`else
  localparam int T3_WINDOWS = 4;
`endif

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && done_a !== 1'b1; i++) step(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0;
    #3 rst_n = 1'b0;
    step(2);
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", req_a); end
    total++; if (calls_a !== 16'd0) begin bad++; $display("FAIL rst_calls got=%0d want=0", calls_a); end
    total++; if (fails_a !== 16'd0) begin bad++; $display("FAIL rst_fails got=%0d want=0", fails_a); end
    total++; if (last_a !== 32'd0) begin bad++; $display("FAIL rst_last got=%0h want=0", last_a); end
    total++; if ({to_a, done_a, pass_a} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {to_a, done_a, pass_a}); end
    total++; if ({req_b, done_b} !== 2'b00) begin bad++; $display("FAIL rst_b got=%b want=00", {req_b, done_b}); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_idle;
    step(30);
    total++; if (rises_a !== 0) begin bad++; $display("FAIL idle_req got=%0d want=0", rises_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL idle_done got=%b want=0", done_a); end
  endtask

  // T1 plus start-to-req latency.
  task automatic test_normal;
    mode_a = 0;
    start_a = 1'b1;
    step(11);
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL t1_req_early got=%b want=0", req_a); end
    step(1);
    total++; if (req_a !== 1'b1) begin bad++; $display("FAIL t1_req_rise got=%b want=1", req_a); end
    wait_done_a(400);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL t1_done got=%b want=1", done_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL t1_pass got=%b want=1", pass_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL t1_calls got=%0d want=4", calls_a); end
    total++; if (fails_a !== 16'd0) begin bad++; $display("FAIL t1_fails got=%0d want=0", fails_a); end
    total++; if (last_a !== 32'd1) begin bad++; $display("FAIL t1_last got=%0h want=1", last_a); end
    total++; if (to_a !== 1'b0) begin bad++; $display("FAIL t1_timeout got=%b want=0", to_a); end
    total++; if (rises_a !== 4) begin bad++; $display("FAIL t1_rises got=%0d want=4", rises_a); end
    total++; if (maxw_a !== 2 || minw_a !== 2) begin bad++; $display("FAIL t1_width got=%0d/%0d want=2/2", minw_a, maxw_a); end
    total++; if (ival_a !== 12) begin bad++; $display("FAIL t1_period got=%0d want=12", ival_a); end
  endtask

  task automatic test_start_ignored;
    start_a = 1'b0;
    step(3);
    start_a = 1'b1;
    step(30);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL hold_done got=%b want=1", done_a); end
    total++; if (rises_a !== 4) begin bad++; $display("FAIL hold_rises got=%0d want=4", rises_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL hold_calls got=%0d want=4", calls_a); end
  endtask

  task automatic test_mismatch;
    do_reset();
    mode_a = 1;
    start_a = 1'b1;
    wait_done_a(400);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL t2_done got=%b want=1", done_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL t2_pass got=%b want=0", pass_a); end
    total++; if (fails_a !== 16'd1) begin bad++; $display("FAIL t2_fails got=%0d want=1", fails_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL t2_calls got=%0d want=4", calls_a); end
    total++; if (to_a !== 1'b0) begin bad++; $display("FAIL t2_timeout got=%b want=0", to_a); end
    total++; if (last_a !== 32'd1) begin bad++; $display("FAIL t2_last got=%0h want=1", last_a); end
  endtask

  task automatic test_ack_timeout;
    do_reset();
    mode_a = 2;
    start_a = 1'b1;
    wait_done_a(600);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL t3_done got=%b want=1", done_a); end
    total++; if (to_a !== 1'b1) begin bad++; $display("FAIL t3_timeout got=%b want=1", to_a); end
    total++; if (fails_a !== 16'd4) begin bad++; $display("FAIL t3_fails got=%0d want=4", fails_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL t3_calls got=%0d want=4", calls_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL t3_pass got=%b want=0", pass_a); end
    total++; if (rises_a !== T3_WINDOWS) begin bad++; $display("FAIL t3_windows got=%0d want=%0d", rises_a, T3_WINDOWS); end
    total++; if (maxw_a !== 16 || minw_a !== 16) begin bad++; $display("FAIL t3_width got=%0d/%0d want=16/16", minw_a, maxw_a); end
    total++; if (ival_a !== 20) begin bad++; $display("FAIL t3_period got=%0d want=20", ival_a); end
    total++; if (last_a !== 32'd0) begin bad++; $display("FAIL t3_last got=%0h want=0", last_a); end
  endtask

  task automatic test_run_timeout;
    do_reset();
    mode_a = 3;
    start_a = 1'b1;
    wait_done_a(1000);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL t4_done got=%b want=1", done_a); end
    total++; if (to_a !== 1'b1) begin bad++; $display("FAIL t4_timeout got=%b want=1", to_a); end
    total++; if (fails_a !== 16'd4) begin bad++; $display("FAIL t4_fails got=%0d want=4", fails_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL t4_calls got=%0d want=4", calls_a); end
    total++; if (minw_a !== 1 || maxw_a !== 2) begin bad++; $display("FAIL t4_width got=%0d/%0d want=1/2", minw_a, maxw_a); end
    // 1 req cycle + 50 run cycles + 4 gap cycles between rises.
    total++; if (ival_a !== 55) begin bad++; $display("FAIL t4_period got=%0d want=55", ival_a); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    mode_a = 0;
    start_a = 1'b1;
    for (int i = 0; i < 200 && ncalls_a < 2; i++) step(1);
    step(1);
    total++; if (ncalls_a !== 2 || busy_a !== 1'b1) begin bad++; $display("FAIL t5_reach got=%0d/%b want=2/1", ncalls_a, busy_a); end
    total++; if (calls_a !== 16'd1) begin bad++; $display("FAIL t5_precalls got=%0d want=1", calls_a); end
    rst_n = 1'b0; start_a = 1'b0;
    #1;
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL t5_req got=%b want=0", req_a); end
    total++; if (calls_a !== 16'd0 || fails_a !== 16'd0) begin bad++; $display("FAIL t5_counts got=%0d/%0d want=0/0", calls_a, fails_a); end
    total++; if (last_a !== 32'd0) begin bad++; $display("FAIL t5_last got=%0h want=0", last_a); end
    step(2);
    rst_n = 1'b1;
    step(1);
    start_a = 1'b1;
    wait_done_a(400);
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL t5_pass got=%b want=1", pass_a); end
    total++; if (calls_a !== 16'd4) begin bad++; $display("FAIL t5_calls got=%0d want=4", calls_a); end
  endtask

  task automatic test_zero_gap;
    do_reset();
    start_b = 1'b1;
    step(1);
    total++; if (req_b !== 1'b0) begin bad++; $display("FAIL t6_req_early got=%b want=0", req_b); end
    step(1);
    total++; if (req_b !== 1'b1) begin bad++; $display("FAIL t6_req_rise got=%b want=1", req_b); end
    for (int i = 0; i < 200 && done_b !== 1'b1; i++) step(1);
    total++; if (done_b !== 1'b1) begin bad++; $display("FAIL t6_done got=%b want=1", done_b); end
    total++; if (pass_b !== 1'b1) begin bad++; $display("FAIL t6_pass got=%b want=1", pass_b); end
    total++; if (calls_b !== 16'd3 || fails_b !== 16'd0) begin bad++; $display("FAIL t6_counts got=%0d/%0d want=3/0", calls_b, fails_b); end
    total++; if (rises_b !== 3 || maxw_b !== 1) begin bad++; $display("FAIL t6_pulses got=%0d/%0d want=3/1", rises_b, maxw_b); end
    total++; if (ival_b !== 4) begin bad++; $display("FAIL t6_period got=%0d want=4", ival_b); end
    total++; if (last_b !== 8'hA5 || to_b !== 1'b0) begin bad++; $display("FAIL t6_last got=%0h/%b want=a5/0", last_b, to_b); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_normal();
    test_start_ignored();
    test_mismatch();
    test_ack_timeout();
    test_run_timeout();
    test_reset_mid_run();
    test_zero_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
